// File: rtl/dds_pkg.sv
// Shared types and defaults for the DDS frequency-sweep controller.
package dds_pkg;

  localparam int TW_W_DEF    = 8;
  localparam int DWELL_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [TW_W_DEF-1:0] tw_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Config/control bundle between the register front-end and the sweep controller.
// Optional `loop` input exists only when DDS_SWEEP_LOOP_EN is defined.
interface dds_sweep_ctrl_if #(
  parameter int TW_W    = dds_pkg::TW_W_DEF,
  parameter int DWELL_W = dds_pkg::DWELL_W_DEF
) ();
  import dds_pkg::*;

  // start is a level request, taken only while the controller is IDLE and abort
  // is low; the config fields must be valid in that same cycle and are latched.
  logic               start;
  logic               abort;
  logic [TW_W-1:0]    f_start;
  logic [TW_W-1:0]    f_stop;
  logic [TW_W-1:0]    f_step;
  logic [DWELL_W-1:0] dwell;
`ifdef DDS_SWEEP_LOOP_EN
  logic               loop;
`endif
  logic [TW_W-1:0]    tw_out;
  logic               tw_valid;
  logic               acc_reset;
  logic               busy;
  logic               done;
  state_t             dbg_state;

  modport master (
    output start, abort, f_start, f_stop, f_step, dwell,
`ifdef DDS_SWEEP_LOOP_EN
    output loop,
`endif
    input  tw_out, tw_valid, acc_reset, busy, done, dbg_state
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_step, dwell,
`ifdef DDS_SWEEP_LOOP_EN
    input  loop,
`endif
    output tw_out, tw_valid, acc_reset, busy, done, dbg_state
  );

endinterface

// File: rtl/dds_dwell_timer.sv
// Dwell counter: clear/enable with a terminal-count compare against the held dwell value.
module dds_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] term,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer driving the phase accumulator's tuning word and reset.
// Define DDS_SWEEP_LOOP_EN to add the `loop` input for continuous re-sweeping.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int TW_W    = TW_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  dds_sweep_ctrl_if.slave  bus
);

  state_t             state_q, state_d;
  logic [TW_W-1:0]    tw_q, tw_d;
  logic [TW_W-1:0]    fstart_q, fstop_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_q;
  logic               latch_cfg;
  logic               tmr_clr, tmr_en, tmr_tc;

  // Next word is clamped to f_stop instead of ever wrapping past it.
  function automatic logic [TW_W-1:0] next_word(
    input logic [TW_W-1:0] tw,
    input logic [TW_W-1:0] step,
    input logic [TW_W-1:0] stop,
    input logic            down
  );
    logic [TW_W:0]   sum;
    logic [TW_W-1:0] diff;
    sum  = {1'b0, tw} + {1'b0, step};
    diff = tw - step;
    if (step == '0) begin
      return stop;
    end else if (!down) begin
      return (sum >= {1'b0, stop}) ? stop : sum[TW_W-1:0];
    end else begin
      return ((tw < step) || (diff <= stop)) ? stop : diff;
    end
  endfunction

  dds_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (dwell_q),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    tw_d      = tw_q;
    latch_cfg = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tw_d    = '0;
        tmr_clr = 1'b1;
        if (bus.start && !bus.abort) begin
          state_d   = LOAD;
          tw_d      = bus.f_start;
          latch_cfg = 1'b1;
        end
      end
      LOAD: begin
        tmr_clr = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
          tw_d    = '0;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          tw_d    = '0;
          tmr_clr = 1'b1;
        end else if (tmr_tc) begin
          tmr_clr = 1'b1;
          if (tw_q == fstop_q) begin
            state_d = DONE;
`ifdef DDS_SWEEP_LOOP_EN
            if (bus.loop) begin
              state_d = LOAD;
              tw_d    = fstart_q;
            end
`endif
          end else begin
            tw_d = next_word(tw_q, step_q, fstop_q, dir_q);
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        tw_d    = '0;
        tmr_clr = 1'b1;
      end
      default: begin
        state_d = IDLE;
        tw_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tw_q     <= '0;
      fstart_q <= '0;
      fstop_q  <= '0;
      step_q   <= '0;
      dwell_q  <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tw_q    <= tw_d;
      if (latch_cfg) begin
        fstart_q <= bus.f_start;
        fstop_q  <= bus.f_stop;
        step_q   <= bus.f_step;
        dwell_q  <= bus.dwell;
        dir_q    <= (bus.f_stop < bus.f_start);
      end
    end
  end

  // All flags decode straight from the registered state, so they are glitch-free.
  assign bus.tw_out    = tw_q;
  assign bus.tw_valid  = (state_q == RUN);
  assign bus.acc_reset = (state_q == LOAD);
  assign bus.busy      = (state_q == LOAD) || (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Randomized bench for dds_sweep_ctrl against a per-cycle trace model of each sweep.
// Exercises the loop option when DDS_SWEEP_LOOP_EN is defined.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int TW  = 8;
  localparam int DW  = 8;
  localparam int OW  = TW + 4;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] obs;

  dds_sweep_ctrl_if #(.TW_W(TW), .DWELL_W(DW)) bus ();

  dds_sweep_ctrl #(.TW_W(TW), .DWELL_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign obs = {bus.tw_out, bus.tw_valid, bus.acc_reset, bus.busy, bus.done};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] pack(input int w, input bit v, input bit a,
                                         input bit b, input bit d);
    tw_t t;
    t = w[TW-1:0];
    return {t, v, a, b, d};
  endfunction

  // Expected outputs, one entry per cycle from the LOAD cycle to the first IDLE cycle.
  task automatic build_exp(input int fs, input int fp, input int st, input int dw);
    int w, n;
    exp_q.delete();
    exp_q.push_back(pack(fs, 0, 1, 1, 0));
    w = fs;
    forever begin
      repeat (dw + 1) exp_q.push_back(pack(w, 1, 0, 1, 0));
      if (w == fp) break;
      if (fp > fs) begin
        n = w + st;
        if (st == 0 || n >= fp) n = fp;
      end else begin
        n = w - st;
        if (st == 0 || n <= fp) n = fp;
      end
      w = n;
    end
    exp_q.push_back(pack(fp, 0, 0, 0, 1));
    exp_q.push_back(pack(0, 0, 0, 0, 0));
  endtask

  // driver tasks: all called and returning at a falling edge
  task automatic drive_start(input int fs, input int fp, input int st, input int dw);
    bus.f_start = fs[TW-1:0];
    bus.f_stop  = fp[TW-1:0];
    bus.f_step  = st[TW-1:0];
    bus.dwell   = dw[DW-1:0];
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic run_sweep(input string tag, input int fs, input int fp, input int st,
                           input int dw, input bit noise);
    logic [OW-1:0] e;
    build_exp(fs, fp, st, dw);
    drive_start(fs, fp, st, dw);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(tag, obs, e);
      if (exp_q.size() == 0) break;
      if (noise) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.f_start = TW'($urandom);
        bus.f_stop  = TW'($urandom);
        bus.f_step  = TW'($urandom);
        bus.dwell   = DW'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic run_interrupt(input string tag, input int fs, input int fp, input int st,
                               input int dw, input int k_in, input bit use_reset);
    int k;
    logic [OW-1:0] e;
    build_exp(fs, fp, st, dw);
    k = (k_in > 0) ? k_in : $urandom_range(1, exp_q.size() - 2);
    drive_start(fs, fp, st, dw);
    for (int i = 0; i < k; i++) begin
      e = exp_q.pop_front();
      check_eq(tag, obs, e);
      if (i < k - 1) @(negedge clk);
    end
    if (use_reset) reset = 1'b1;
    else bus.abort = 1'b1;
    @(negedge clk);
    check_eq({tag, "_cut"}, obs, pack(0, 0, 0, 0, 0));
    reset     = 1'b0;
    bus.abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq({tag, "_idle"}, obs, pack(0, 0, 0, 0, 0));
    end
  endtask

`ifdef DDS_SWEEP_LOOP_EN
  task automatic run_loop();
    int idx;
    logic [OW-1:0] e;
    exp_q.delete();
    repeat (3) begin
      exp_q.push_back(pack(1, 0, 1, 1, 0));
      exp_q.push_back(pack(1, 1, 0, 1, 0));
      exp_q.push_back(pack(3, 1, 0, 1, 0));
    end
    exp_q.push_back(pack(3, 0, 0, 0, 1));
    exp_q.push_back(pack(0, 0, 0, 0, 0));
    bus.loop = 1'b1;
    drive_start(1, 3, 2, 0);
    idx = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("loop", obs, e);
      idx++;
      if (idx == 7) bus.loop = 1'b0;
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    bus.loop = 1'b0;
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.f_start  = '0;
    bus.f_stop   = '0;
    bus.f_step   = '0;
    bus.dwell    = '0;
`ifdef DDS_SWEEP_LOOP_EN
    bus.loop     = 1'b0;
`endif
    @(negedge clk);
    check_eq("rst_out", obs, pack(0, 0, 0, 0, 0));
    check_eq("rst_state", bus.dbg_state, IDLE);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_out", obs, pack(0, 0, 0, 0, 0));

    run_sweep("up",       2,  10,  3, 1, 1'b0);
    run_sweep("down",     200, 5, 60, 0, 1'b1);
    run_sweep("ovf",      250, 255, 10, 2, 1'b0);
    run_sweep("single",   7,   7,  4, 3, 1'b1);
    run_sweep("step0",    2,   9,  0, 1, 1'b0);
    run_sweep("dn_step0", 9,   2,  0, 0, 1'b1);

    // start held together with abort in IDLE must not launch a sweep
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.f_start = 8'd4;
    bus.f_stop  = 8'd8;
    repeat (3) begin
      @(negedge clk);
      check_eq("start_abort", obs, pack(0, 0, 0, 0, 0));
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;

    run_interrupt("abort_w2", 10, 50, 10, 1, 4, 1'b0);
    run_interrupt("abort_ld", 10, 50, 10, 1, 1, 1'b0);
    run_interrupt("reset_run", 2, 10, 3, 1, 5, 1'b1);

    for (int n = 0; n < 6; n++) begin
      run_interrupt($sformatf("rnd_cut%0d", n), $urandom_range(0, 255), $urandom_range(0, 255),
                    $urandom_range(1, 64), $urandom_range(0, 2), 0, 1'(n % 2));
    end

    for (int n = 0; n < 25; n++) begin
      run_sweep($sformatf("rnd%0d", n), $urandom_range(0, 255), $urandom_range(0, 255),
                ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 64),
                $urandom_range(0, 2), 1'(n % 2));
    end

`ifdef DDS_SWEEP_LOOP_EN
    run_loop();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
